// File: rtl/bpm_capture_ring_if.sv
// bpm_capture_ring_if: control, sample input and readout stream of the capture ring
interface bpm_capture_ring_if #(
   parameter int DATA_W = 16,
   parameter int NCH    = 2,
   parameter int ADDR_W = 9
);
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
   logic                  arm;
   logic                  trig;
   logic                  din_valid;
   logic [NCH*DATA_W-1:0] din;
   logic                  busy;
   logic [2:0]            state;
   logic [ADDR_W-1:0]     trig_addr;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [DATA_W-1:0]     rd_data;
   logic [CH_W-1:0]       rd_ch;
   logic                  rd_last;
   modport slave (
      input  arm, trig, din_valid, din, rd_ready,
      output busy, state, trig_addr, rd_valid, rd_data, rd_ch, rd_last
   );
   modport master (
      output arm, trig, din_valid, din, rd_ready,
      input  busy, state, trig_addr, rd_valid, rd_data, rd_ch, rd_last
   );
endinterface

// File: rtl/bpm_capture_ring.sv
// bpm_capture_ring: multi-channel pre/post-trigger circular capture buffer with oldest-first readout
module bpm_capture_ring #(
   parameter int DATA_W = 16,
   parameter int NCH    = 2,
   parameter int ADDR_W = 9,
   parameter int POST   = 128
) (
   input logic               clk,
   input logic               rst_n,
   bpm_capture_ring_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam bit POST1 = (POST == 1);
   typedef logic [ADDR_W:0] cnt_t;
   typedef logic [CH_W-1:0] ch_t;
   localparam cnt_t PRE_N   = cnt_t'(DEPTH - POST);
   localparam cnt_t POST_N  = cnt_t'(POST);
   localparam cnt_t DEPTH_N = cnt_t'(DEPTH);
   localparam ch_t  LAST_CH = ch_t'(NCH - 1);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_ARMED = 3'd2,
      S_POST  = 3'd3,
      S_READ  = 3'd4
   } state_t;

   logic [NCH-1:0][DATA_W-1:0] mem [DEPTH];
   state_t            st;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] taddr;
   cnt_t              cnt;
   ch_t               lane;
   logic              valid;
   logic [DATA_W-1:0] data;
   ch_t               ch;
   logic              last;
   logic              we;
   logic              adv;

   assign we            = bus.din_valid && (st == S_FILL || st == S_ARMED || st == S_POST);
   assign adv           = !valid || bus.rd_ready;
   assign bus.busy      = st != S_IDLE;
   assign bus.state     = st;
   assign bus.trig_addr = taddr;
   assign bus.rd_valid  = valid;
   assign bus.rd_data   = data;
   assign bus.rd_ch     = ch;
   assign bus.rd_last   = last;

   // Ring write: all lanes of one sample set share the write address
   always_ff @(posedge clk)
      if (we) mem[wr_ptr] <= bus.din;

   // Capture FSM; cnt counts fill, then post-trigger samples, then read addresses
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st      <= S_IDLE;
         wr_ptr  <= '0;
         rd_addr <= '0;
         taddr   <= '0;
         cnt     <= '0;
         lane    <= '0;
         valid   <= 1'b0;
         data    <= '0;
         ch      <= '0;
         last    <= 1'b0;
      end else begin
         if (we) wr_ptr <= wr_ptr + 1'b1;
         case (st)
            S_IDLE:
               if (bus.arm) begin
                  st     <= S_FILL;
                  wr_ptr <= '0;
                  cnt    <= '0;
               end
            S_FILL:
               if (bus.din_valid) begin
                  st  <= (cnt == PRE_N - 1'b1) ? S_ARMED : S_FILL;
                  cnt <= (cnt == PRE_N - 1'b1) ? '0 : cnt + 1'b1;
               end
            S_ARMED:
               if (bus.trig) begin
                  taddr   <= wr_ptr;
                  st      <= (bus.din_valid && POST1) ? S_READ : S_POST;
                  cnt     <= (bus.din_valid && POST1) ? '0 : cnt_t'(bus.din_valid);
                  rd_addr <= wr_ptr + 1'b1;
                  lane    <= '0;
               end
            S_POST:
               if (bus.din_valid) begin
                  st      <= (cnt == POST_N - 1'b1) ? S_READ : S_POST;
                  cnt     <= (cnt == POST_N - 1'b1) ? '0 : cnt + 1'b1;
                  rd_addr <= wr_ptr + 1'b1;
                  lane    <= '0;
               end
            S_READ:
               if (adv) begin
                  if (cnt != DEPTH_N) begin
                     valid   <= 1'b1;
                     data    <= mem[rd_addr][lane];
                     ch      <= lane;
                     last    <= (cnt == DEPTH_N - 1'b1) && (lane == LAST_CH);
                     lane    <= (lane == LAST_CH) ? '0 : lane + 1'b1;
                     rd_addr <= (lane == LAST_CH) ? rd_addr + 1'b1 : rd_addr;
                     cnt     <= (lane == LAST_CH) ? cnt + 1'b1 : cnt;
                  end else if (valid) begin
                     valid <= 1'b0;
                     last  <= 1'b0;
                     st    <= S_IDLE;
                  end
               end
            default: st <= S_IDLE;
         endcase
      end
endmodule
